// File: rtl/spi_reg_bank.sv
// ============================================================================
// spi_reg_bank : SPI-attached register file with burst auto-increment
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_reg_bank #(
  parameter logic [7:0] FPGA_VER      = 8'hC2,
  parameter logic [7:0] UART_INV_RST  = 8'h00,
  parameter logic [7:0] TELEM_SEL_RST = 8'h00
) (
  input  logic       clk_core,
  input  logic       reset_n,
  input  logic       transaction_begin,
  input  logic       rx_byte_available,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic       bootloader_force_pin,
  output logic [7:0] uart_inverted,
  output logic [7:0] telemetry_con_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] sync;
  logic       byte_evt;
  logic [6:0] addr;
  logic       dir_write;
  logic [7:0] scratch;
  logic [7:0] wr_count;
  logic [7:0] err_count;

  logic       start;
  logic       load_addr;
  logic       wr_strobe;
  logic       rd_strobe;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], rx_byte_available};
    end
  end

  assign byte_evt = sync[1] & ~sync[2];

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A begin pulse always wins over a coincident byte, which is then dropped.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    load_addr  = 1'b0;
    wr_strobe  = 1'b0;
    rd_strobe  = 1'b0;
    if (transaction_begin) begin
      next_state = ADDR;
      start      = 1'b1;
    end else if (byte_evt) begin
      case (state)
        ADDR: begin
          load_addr  = 1'b1;
          next_state = DATA;
        end
        DATA: begin
          wr_strobe = dir_write;
          rd_strobe = ~dir_write;
        end
        default: next_state = state;
      endcase
    end
  end

  // The address byte reads straight from rx_byte; burst reads prefetch addr+1.
  assign rd_addr = (state == ADDR) ? rx_byte[6:0] : (addr + 7'd1);

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      7'h00:   rd_data = FPGA_VER;
      7'h01:   rd_data = {7'b0, bootloader_force_pin};
      7'h02:   rd_data = uart_inverted;
      7'h03:   rd_data = telemetry_con_sel;
      7'h04:   rd_data = scratch;
      7'h05:   rd_data = wr_count;
      7'h06:   rd_data = err_count;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      addr                 <= 7'h00;
      dir_write            <= 1'b0;
      tx_byte              <= 8'h00;
      bootloader_force_pin <= 1'b0;
      uart_inverted        <= UART_INV_RST;
      telemetry_con_sel    <= TELEM_SEL_RST;
      scratch              <= 8'h00;
      wr_count             <= 8'h00;
      err_count            <= 8'h00;
    end else if (start) begin
      tx_byte <= 8'h00;
    end else if (load_addr) begin
      addr      <= rx_byte[6:0];
      dir_write <= rx_byte[7];
      if (!rx_byte[7]) begin
        tx_byte <= rd_data;
      end
    end else if (wr_strobe) begin
      addr <= addr + 7'd1;
      case (addr)
        7'h01: begin
          bootloader_force_pin <= rx_byte[0];
          wr_count             <= wr_count + 8'd1;
        end
        7'h02: begin
          uart_inverted <= rx_byte;
          wr_count      <= wr_count + 8'd1;
        end
        7'h03: begin
          telemetry_con_sel <= rx_byte;
          wr_count          <= wr_count + 8'd1;
        end
        7'h04: begin
          scratch  <= rx_byte;
          wr_count <= wr_count + 8'd1;
        end
        7'h06: err_count <= 8'h00;
        default: begin
          if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
        end
      endcase
    end else if (rd_strobe) begin
      addr    <= addr + 7'd1;
      tx_byte <= rd_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
// ============================================================================
// tb_spi_reg_bank : directed self-checking bench for spi_reg_bank
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_reg_bank;

  logic       clk_core = 1'b0;
  logic       reset_n;
  logic       transaction_begin;
  logic       rx_byte_available;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       bootloader_force_pin;
  logic [7:0] uart_inverted;
  logic [7:0] telemetry_con_sel;

  int checks = 0;
  int passed = 0;

  spi_reg_bank #(
    .FPGA_VER      (8'hC2),
    .UART_INV_RST  (8'h00),
    .TELEM_SEL_RST (8'h00)
  ) dut (
    .clk_core             (clk_core),
    .reset_n              (reset_n),
    .transaction_begin    (transaction_begin),
    .rx_byte_available    (rx_byte_available),
    .rx_byte              (rx_byte),
    .tx_byte              (tx_byte),
    .bootloader_force_pin (bootloader_force_pin),
    .uart_inverted        (uart_inverted),
    .telemetry_con_sel    (telemetry_con_sel)
  );

  always #10 clk_core = ~clk_core;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end

  task automatic pulse_begin();
    @(negedge clk_core);
    transaction_begin = 1'b1;
    @(negedge clk_core);
    transaction_begin = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_core);
    rx_byte           = b;
    rx_byte_available = 1'b1;
    repeat (5) @(posedge clk_core);
    @(negedge clk_core);
    rx_byte_available = 1'b0;
    repeat (3) @(posedge clk_core);
    #1;
  endtask

  task automatic read_reg(input logic [6:0] a, output logic [7:0] d);
    pulse_begin();
    send_byte({1'b0, a});
    d = tx_byte;
  endtask

  task automatic test_reset();
    logic found;
    reset_n           = 1'b0;
    transaction_begin = 1'b0;
    rx_byte_available = 1'b0;
    rx_byte           = 8'h00;
    repeat (3) @(posedge clk_core);
    #1;
    checks++;
    if (tx_byte !== 8'h00) $display("FAIL reset_tx: got %h want 00", tx_byte);
    else passed++;
    checks++;
    if (bootloader_force_pin !== 1'b0) $display("FAIL reset_pin: got %b want 0", bootloader_force_pin);
    else passed++;
    checks++;
    if (uart_inverted !== 8'h00) $display("FAIL reset_uart: got %h want 00", uart_inverted);
    else passed++;
    checks++;
    if (telemetry_con_sel !== 8'h00) $display("FAIL reset_telem: got %h want 00", telemetry_con_sel);
    else passed++;
    @(negedge clk_core);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_core);

    pulse_begin();
    @(negedge clk_core);
    rx_byte           = 8'h00;
    rx_byte_available = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(posedge clk_core);
      #1;
      if (tx_byte === 8'hC2) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL ver_poll: got %h want C2 within 4 clks", tx_byte);
    else passed++;
    @(negedge clk_core);
    rx_byte_available = 1'b0;
    repeat (3) @(posedge clk_core);
  endtask

  task automatic test_burst_write();
    logic [7:0] d;
    pulse_begin();
    send_byte(8'h82);
    send_byte(8'hA5);
    send_byte(8'h3C);
    checks++;
    if (uart_inverted !== 8'hA5) $display("FAIL bw_uart: got %h want A5", uart_inverted);
    else passed++;
    checks++;
    if (telemetry_con_sel !== 8'h3C) $display("FAIL bw_telem: got %h want 3C", telemetry_con_sel);
    else passed++;
    read_reg(7'h05, d);
    checks++;
    if (d !== 8'h02) $display("FAIL bw_wrcount: got %h want 02", d);
    else passed++;

    pulse_begin();
    send_byte(8'h02);
    checks++;
    if (tx_byte !== 8'hA5) $display("FAIL br_02: got %h want A5", tx_byte);
    else passed++;
    send_byte(8'hEE);
    checks++;
    if (tx_byte !== 8'h3C) $display("FAIL br_03: got %h want 3C", tx_byte);
    else passed++;
    send_byte(8'hEE);
    checks++;
    if (tx_byte !== 8'h00) $display("FAIL br_04: got %h want 00", tx_byte);
    else passed++;
    checks++;
    if (uart_inverted !== 8'hA5) $display("FAIL br_nowrite: got %h want A5", uart_inverted);
    else passed++;
  endtask

  task automatic test_err_count();
    logic [7:0] d;
    pulse_begin();
    send_byte(8'h80);
    send_byte(8'h11);
    read_reg(7'h06, d);
    checks++;
    if (d !== 8'h01) $display("FAIL err_inc: got %h want 01", d);
    else passed++;
    read_reg(7'h00, d);
    checks++;
    if (d !== 8'hC2) $display("FAIL ver_ro: got %h want C2", d);
    else passed++;
    pulse_begin();
    send_byte(8'h86);
    send_byte(8'h00);
    read_reg(7'h06, d);
    checks++;
    if (d !== 8'h00) $display("FAIL err_clr: got %h want 00", d);
    else passed++;
    read_reg(7'h05, d);
    checks++;
    if (d !== 8'h02) $display("FAIL err_wrcount: got %h want 02", d);
    else passed++;
  endtask

  task automatic test_wrap_read();
    pulse_begin();
    send_byte(8'h7F);
    checks++;
    if (tx_byte !== 8'h00) $display("FAIL wrap_7f: got %h want 00", tx_byte);
    else passed++;
    send_byte(8'h55);
    checks++;
    if (tx_byte !== 8'hC2) $display("FAIL wrap_00: got %h want C2", tx_byte);
    else passed++;
    send_byte(8'h55);
    checks++;
    if (tx_byte !== 8'h00) $display("FAIL wrap_01: got %h want 00", tx_byte);
    else passed++;
  endtask

  task automatic test_pin_and_write_wrap();
    logic [7:0] d;
    pulse_begin();
    send_byte(8'h81);
    send_byte(8'hFF);
    checks++;
    if (bootloader_force_pin !== 1'b1) $display("FAIL pin_set: got %b want 1", bootloader_force_pin);
    else passed++;
    read_reg(7'h01, d);
    checks++;
    if (d !== 8'h01) $display("FAIL pin_read: got %h want 01", d);
    else passed++;

    // 0x7F and 0x00 are error writes, then the wrapped burst lands on 0x01.
    pulse_begin();
    send_byte(8'hFF);
    send_byte(8'h12);
    send_byte(8'h99);
    send_byte(8'h00);
    checks++;
    if (bootloader_force_pin !== 1'b0) $display("FAIL wwrap_pin: got %b want 0", bootloader_force_pin);
    else passed++;
    read_reg(7'h06, d);
    checks++;
    if (d !== 8'h02) $display("FAIL wwrap_err: got %h want 02", d);
    else passed++;
    read_reg(7'h05, d);
    checks++;
    if (d !== 8'h04) $display("FAIL wwrap_wrcount: got %h want 04", d);
    else passed++;
  endtask

  task automatic test_begin_collision();
    pulse_begin();
    send_byte(8'h84);
    send_byte(8'h33);
    pulse_begin();
    send_byte(8'h04);
    checks++;
    if (tx_byte !== 8'h33) $display("FAIL col_pre: got %h want 33", tx_byte);
    else passed++;
    @(negedge clk_core);
    rx_byte           = 8'h5A;
    rx_byte_available = 1'b1;
    @(posedge clk_core);
    @(posedge clk_core);
    @(negedge clk_core);
    transaction_begin = 1'b1;
    @(posedge clk_core);
    #1;
    checks++;
    if (tx_byte !== 8'h00) $display("FAIL col_tx: got %h want 00", tx_byte);
    else passed++;
    @(negedge clk_core);
    transaction_begin = 1'b0;
    rx_byte_available = 1'b0;
    repeat (3) @(posedge clk_core);
    send_byte(8'h04);
    checks++;
    if (tx_byte !== 8'h33) $display("FAIL col_addr: got %h want 33", tx_byte);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] d;
    pulse_begin();
    send_byte(8'h83);
    @(negedge clk_core);
    rx_byte           = 8'h66;
    rx_byte_available = 1'b1;
    @(posedge clk_core);
    @(negedge clk_core);
    reset_n = 1'b0;
    repeat (2) @(posedge clk_core);
    @(negedge clk_core);
    reset_n           = 1'b1;
    rx_byte_available = 1'b0;
    repeat (4) @(posedge clk_core);
    #1;
    checks++;
    if (telemetry_con_sel !== 8'h00) $display("FAIL rst_telem: got %h want 00", telemetry_con_sel);
    else passed++;
    checks++;
    if (uart_inverted !== 8'h00) $display("FAIL rst_uart: got %h want 00", uart_inverted);
    else passed++;
    send_byte(8'h84);
    send_byte(8'h77);
    checks++;
    if (tx_byte !== 8'h00) $display("FAIL rst_ignored_tx: got %h want 00", tx_byte);
    else passed++;
    read_reg(7'h04, d);
    checks++;
    if (d !== 8'h00) $display("FAIL rst_scratch: got %h want 00", d);
    else passed++;
    read_reg(7'h05, d);
    checks++;
    if (d !== 8'h00) $display("FAIL rst_wrcount: got %h want 00", d);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_err_count();
    test_wrap_read();
    test_pin_and_write_wrap();
    test_begin_collision();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
